// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Package     : game_pkg
// Description : Shared key codes, page codes, opcodes, directions and the
//               state-pack helper for the battle sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    // Key codes delivered by the keyboard decoder
    localparam logic [3:0] c_key_none  = 4'd0;
    localparam logic [3:0] c_key_w     = 4'd1;
    localparam logic [3:0] c_key_d     = 4'd2;
    localparam logic [3:0] c_key_s     = 4'd3;
    localparam logic [3:0] c_key_a     = 4'd4;
    localparam logic [3:0] c_key_space = 4'd5;

    // Page codes (upper nibble of state)
    typedef enum logic [3:0] {
        PAGE_MENU   = 4'h1,
        PAGE_WIN    = 4'h2,
        PAGE_LOSE   = 4'h3,
        PAGE_START  = 4'h8,
        PAGE_DODGE  = 4'h9,
        PAGE_ATTACK = 4'hA,
        PAGE_ACTION = 4'hB
    } page_t;

    // Player/bullet engine opcodes
    localparam logic [3:0] c_op_hpy = 4'h1;
    localparam logic [3:0] c_op_dpy = 4'h2;
    localparam logic [3:0] c_op_idg = 4'h3;
    localparam logic [3:0] c_op_sdg = 4'h4;
    localparam logic [3:0] c_op_mov = 4'h5;
    localparam logic [3:0] c_op_shp = 4'h6;

    // Movement directions carried in the MOV instruction
    localparam logic [7:0] c_dir_up    = 8'd0;
    localparam logic [7:0] c_dir_left  = 8'd1;
    localparam logic [7:0] c_dir_down  = 8'd2;
    localparam logic [7:0] c_dir_right = 8'd3;

    // Packs page and substage into the externally visible state byte
    function automatic logic [7:0] pack_state(input page_t page, input logic [3:0] sub);
        return {page, sub};
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_edge.sv
`default_nettype none
// ============================================================================
// Module      : key_edge
// Description : Registers the previous key code and produces one-cycle press
//               strobes for key codes 1..5 (new code seen this cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module key_edge (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key,
    output logic [5:1] press
);

    logic [3:0] r_key_prev;

    // Remember last cycle's key so a held key only strobes once
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_prev <= 4'd0;
        end else begin
            r_key_prev <= key;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi <= 5; gi++) begin : g_press
            assign press[gi] = (key == 4'(gi)) && (r_key_prev != 4'(gi));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/battle_controller.sv
`default_nettype none
// ============================================================================
// Module      : battle_controller
// Description : Game sequencer: MENU -> START -> DODGE -> ACTION -> ATTACK,
//               dodge-phase timing, action cursor, saturating monster damage,
//               WIN/LOSE detection and MOV instructions to the player engine.
// Revision    : 1.0 - initial release
// ============================================================================
module battle_controller #(
    parameter int unsigned MON_HP_MAX  = 100,
    parameter int unsigned HP_W        = 8,
    parameter int unsigned DODGE_TICKS = 600,
    parameter int unsigned N_ACTIONS   = 4,
    parameter int unsigned TURN_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        key,
    input  logic              tick,
    input  logic              is_death,
    input  logic              atk_pass,
    input  logic [HP_W-1:0]   dmg_mon,
    output logic [7:0]        state,
    output logic [15:0]       player_instr,
    output logic              instr_valid,
    output logic [HP_W-1:0]   mon_dmg,
    output logic [TURN_W-1:0] turn,
    output logic              game_over
);

    import game_pkg::*;

    localparam int unsigned     CNT_W         = (DODGE_TICKS > 1) ? $clog2(DODGE_TICKS) : 1;
    localparam logic [CNT_W-1:0] c_cnt_load    = CNT_W'(DODGE_TICKS - 1);
    localparam logic [3:0]       c_cursor_last = 4'(N_ACTIONS - 1);
    localparam logic [HP_W:0]    c_hp_max      = (HP_W+1)'(MON_HP_MAX);

    page_t              r_page, w_page_nxt;
    logic [3:0]         r_sub, w_sub_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [HP_W-1:0]    r_mon_dmg;
    logic [TURN_W-1:0]  r_turn;
    logic [15:0]        r_instr;
    logic               r_valid;

    logic [5:1]         w_press;
    logic               w_unused_press;
    logic               w_load_cnt, w_turn_inc, w_clr_score, w_mov_en, w_acc;
    logic               w_is_move, w_kill;
    logic [7:0]         w_dir;
    logic [HP_W:0]      w_sum;
    logic [HP_W-1:0]    w_sum_sat;

    key_edge u_key_edge (
        .clk   (clk),
        .rst   (rst),
        .key   (key),
        .press (w_press)
    );

    // W and S presses are only meaningful to the menu screens of other blocks
    assign w_unused_press = w_press[c_key_w] ^ w_press[c_key_s];

    // Decode movement keys (level-sensitive) into a direction
    always_comb begin
        w_is_move = 1'b1;
        w_dir     = c_dir_up;
        case (key)
            c_key_w: w_dir = c_dir_up;
            c_key_a: w_dir = c_dir_left;
            c_key_s: w_dir = c_dir_down;
            c_key_d: w_dir = c_dir_right;
            default: w_is_move = 1'b0;
        endcase
    end

    // Damage sum with one extra bit so overflow is visible for clamping and the kill test
    assign w_sum     = {1'b0, r_mon_dmg} + {1'b0, dmg_mon};
    assign w_sum_sat = w_sum[HP_W] ? {HP_W{1'b1}} : w_sum[HP_W-1:0];
    assign w_kill    = (w_sum >= c_hp_max);
    assign w_acc     = (r_page == PAGE_ATTACK) && atk_pass;

    // Page FSM next-state and datapath control
    always_comb begin
        w_page_nxt  = r_page;
        w_sub_nxt   = r_sub;
        w_load_cnt  = 1'b0;
        w_turn_inc  = 1'b0;
        w_clr_score = 1'b0;
        w_mov_en    = 1'b0;
        case (r_page)
            PAGE_MENU: begin
                if (w_press[c_key_space]) begin
                    w_page_nxt  = PAGE_START;
                    w_sub_nxt   = 4'd0;
                    w_clr_score = 1'b1;
                end
            end
            PAGE_START: begin
                w_page_nxt = PAGE_DODGE;
                w_sub_nxt  = 4'd0;
                w_load_cnt = 1'b1;
            end
            PAGE_DODGE: begin
                if (is_death) begin
                    w_page_nxt = PAGE_LOSE;
                    w_sub_nxt  = 4'd0;
                end else if (tick && (r_cnt == '0)) begin
                    w_page_nxt = PAGE_ACTION;
                    w_sub_nxt  = 4'd0;
                end else begin
                    w_mov_en = w_is_move;
                end
            end
            PAGE_ACTION: begin
                if (is_death) begin
                    w_page_nxt = PAGE_LOSE;
                    w_sub_nxt  = 4'd0;
                end else if (w_press[c_key_d]) begin
                    w_sub_nxt = (r_sub == c_cursor_last) ? 4'd0 : r_sub + 4'd1;
                end else if (w_press[c_key_a]) begin
                    w_sub_nxt = (r_sub == 4'd0) ? c_cursor_last : r_sub - 4'd1;
                end else if (w_press[c_key_space]) begin
                    w_sub_nxt = 4'd0;
                    if (r_sub == 4'd0) begin
                        w_page_nxt = PAGE_ATTACK;
                    end else begin
                        w_page_nxt = PAGE_DODGE;
                        w_load_cnt = 1'b1;
                        w_turn_inc = 1'b1;
                    end
                end
            end
            PAGE_ATTACK: begin
                // A killing blow outranks a simultaneous player death
                if (atk_pass && w_kill) begin
                    w_page_nxt = PAGE_WIN;
                    w_sub_nxt  = 4'd0;
                end else if (is_death) begin
                    w_page_nxt = PAGE_LOSE;
                    w_sub_nxt  = 4'd0;
                end else if (atk_pass) begin
                    w_page_nxt = PAGE_DODGE;
                    w_sub_nxt  = 4'd0;
                    w_load_cnt = 1'b1;
                    w_turn_inc = 1'b1;
                end
            end
            PAGE_WIN, PAGE_LOSE: begin
                if (w_press[c_key_space]) begin
                    w_page_nxt = PAGE_MENU;
                    w_sub_nxt  = 4'd0;
                end
            end
            default: begin
                w_page_nxt = PAGE_MENU;
                w_sub_nxt  = 4'd0;
            end
        endcase
    end

    // Page/substage state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_page <= PAGE_MENU;
            r_sub  <= 4'd0;
        end else begin
            r_page <= w_page_nxt;
            r_sub  <= w_sub_nxt;
        end
    end

    // Dodge-phase tick counter; reload wins over any coincident tick
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_load_cnt) begin
            r_cnt <= c_cnt_load;
        end else if ((r_page == PAGE_DODGE) && tick && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Saturating monster damage accumulator
    always_ff @(posedge clk) begin
        if (rst || w_clr_score) begin
            r_mon_dmg <= '0;
        end else if (w_acc) begin
            r_mon_dmg <= w_sum_sat;
        end
    end

    // Saturating completed-turn counter
    always_ff @(posedge clk) begin
        if (rst || w_clr_score) begin
            r_turn <= '0;
        end else if (w_turn_inc && (r_turn != {TURN_W{1'b1}})) begin
            r_turn <= r_turn + 1'b1;
        end
    end

    // MOV instruction register; the word holds its last value when not moving
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr <= 16'h0000;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_mov_en;
            if (w_mov_en) begin
                r_instr <= {c_op_mov, w_dir, 4'h0};
            end
        end
    end

    assign state        = pack_state(r_page, r_sub);
    assign player_instr = r_instr;
    assign instr_valid  = r_valid;
    assign mon_dmg      = r_mon_dmg;
    assign turn         = r_turn;
    assign game_over    = (r_page == PAGE_WIN) || (r_page == PAGE_LOSE);

endmodule
`default_nettype wire

// File: tb/tb_battle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_battle_controller
// Description : Directed scenarios followed by random play, every cycle
//               compared against a game-rule model of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_battle_controller;

    localparam int DT   = 3;
    localparam int NACT = 4;
    localparam int HPM  = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  key;
    logic        tick;
    logic        is_death;
    logic        atk_pass;
    logic [7:0]  dmg_mon;
    logic [7:0]  state;
    logic [15:0] player_instr;
    logic        instr_valid;
    logic [7:0]  mon_dmg;
    logic [7:0]  turn;
    logic        game_over;

    int n_tests = 0;
    int n_fail  = 0;

    // Rule model: page/cursor as plain numbers, dodge timed by ticks seen
    int          m_page, m_cursor, m_ticks_seen, m_dmg, m_turn, m_prev;
    logic [15:0] m_instr;
    bit          m_valid;

    battle_controller #(
        .MON_HP_MAX  (HPM),
        .HP_W        (8),
        .DODGE_TICKS (DT),
        .N_ACTIONS   (NACT),
        .TURN_W      (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key          (key),
        .tick         (tick),
        .is_death     (is_death),
        .atk_pass     (atk_pass),
        .dmg_mon      (dmg_mon),
        .state        (state),
        .player_instr (player_instr),
        .instr_valid  (instr_valid),
        .mon_dmg      (mon_dmg),
        .turn         (turn),
        .game_over    (game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit pressed(input int k);
        return (int'(key) == k) && (m_prev != k);
    endfunction

    task automatic model_reset();
        m_page = 1; m_cursor = 0; m_ticks_seen = 0; m_dmg = 0; m_turn = 0;
        m_prev = 0; m_instr = 16'h0; m_valid = 0;
    endtask

    task automatic enter_dodge();
        m_page = 9; m_cursor = 0; m_ticks_seen = 0;
    endtask

    task automatic model_step();
        int k;
        int s;
        k = int'(key);
        m_valid = 0;
        case (m_page)
            1: if (pressed(5)) begin m_page = 8; m_cursor = 0; m_dmg = 0; m_turn = 0; end
            8: enter_dodge();
            9: begin
                if (is_death) begin
                    m_page = 3; m_cursor = 0;
                end else begin
                    if (tick) m_ticks_seen++;
                    if (m_ticks_seen == DT) begin
                        m_page = 11; m_cursor = 0;
                    end else if (k >= 1 && k <= 4) begin
                        // W up, A left, S down, D right
                        s = (k == 1) ? 0 : (k == 4) ? 1 : (k == 3) ? 2 : 3;
                        m_instr = 16'h5000 | 16'(s << 4);
                        m_valid = 1;
                    end
                end
            end
            11: begin
                if (is_death) begin
                    m_page = 3; m_cursor = 0;
                end else if (pressed(2)) begin
                    m_cursor = (m_cursor + 1) % NACT;
                end else if (pressed(4)) begin
                    m_cursor = (m_cursor + NACT - 1) % NACT;
                end else if (pressed(5)) begin
                    if (m_cursor == 0) begin
                        m_page = 10;
                    end else begin
                        enter_dodge();
                        if (m_turn < 255) m_turn++;
                    end
                end
            end
            10: begin
                if (atk_pass) begin
                    s = m_dmg + int'(dmg_mon);
                    m_dmg = (s > 255) ? 255 : s;
                end
                if (atk_pass && s >= HPM) begin
                    m_page = 2; m_cursor = 0;
                end else if (is_death) begin
                    m_page = 3; m_cursor = 0;
                end else if (atk_pass) begin
                    enter_dodge();
                    if (m_turn < 255) m_turn++;
                end
            end
            2, 3: if (pressed(5)) begin m_page = 1; m_cursor = 0; end
            default: begin m_page = 1; m_cursor = 0; end
        endcase
        m_prev = k;
    endtask

    // One clock: apply inputs, advance model, compare every output
    task automatic step(input logic r, input logic [3:0] k, input logic t,
                        input logic d, input logic a, input logic [7:0] dm);
        rst = r; key = k; tick = t; is_death = d; atk_pass = a; dmg_mon = dm;
        @(posedge clk);
        if (r) model_reset(); else model_step();
        #1;
        check("state",     32'(state),        32'({m_page[3:0], m_cursor[3:0]}));
        check("instr",     32'(player_instr), 32'(m_instr));
        check("valid",     32'(instr_valid),  32'(m_valid));
        check("mon_dmg",   32'(mon_dmg),      32'(m_dmg));
        check("turn",      32'(turn),         32'(m_turn));
        check("game_over", 32'(game_over),    32'((m_page == 2) || (m_page == 3)));
    endtask

    task automatic k_step(input logic [3:0] k);
        step(1'b0, k, 1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic tick3();
        for (int i = 0; i < DT; i++) step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    endtask

    initial begin
        model_reset();
        // T1: reset
        step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        k_step(4'd0);
        check("t1_state", 32'(state), 32'h10);
        check("t1_mon",   32'(mon_dmg), 32'h0);

        // T2: SPACE held for 5 cycles
        k_step(4'd5); check("t2_start", 32'(state), 32'h80);
        k_step(4'd5); check("t2_dodge", 32'(state), 32'h90);
        k_step(4'd5); k_step(4'd5); k_step(4'd5);
        check("t2_hold", 32'(state), 32'h90);

        // T3: move left, then dodge phase expires
        k_step(4'd4);
        check("t3_instr", 32'(player_instr), 32'h5010);
        check("t3_valid", 32'(instr_valid), 32'h1);
        for (int i = 0; i < DT; i++) step(1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 8'd0);
        check("t3_action", 32'(state), 32'hB0);
        check("t3_valid0", 32'(instr_valid), 32'h0);

        // T4: cursor wraps and non-FIGHT selection
        k_step(4'd0); k_step(4'd4); check("t4_wrap", 32'(state), 32'hB3);
        k_step(4'd0); k_step(4'd2);
        k_step(4'd0); k_step(4'd2); check("t4_b1", 32'(state), 32'hB1);
        k_step(4'd0); k_step(4'd5);
        check("t4_dodge", 32'(state), 32'h90);
        check("t4_turn", 32'(turn), 32'h1);

        // T5: build 90 damage, then kill with coincident death
        tick3(); k_step(4'd5); k_step(4'd0);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 8'd90);
        tick3(); k_step(4'd5); k_step(4'd0);
        check("t5_attack", 32'(state), 32'hA0);
        step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 8'd10);
        check("t5_win", 32'(state), 32'h20);
        check("t5_over", 32'(game_over), 32'h1);
        check("t5_mon", 32'(mon_dmg), 32'd100);
        // Clamp variant: 90 + 200 saturates at 255
        k_step(4'd5); k_step(4'd0); k_step(4'd5); k_step(4'd0);
        tick3(); k_step(4'd5); k_step(4'd0);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 8'd90);
        tick3(); k_step(4'd5); k_step(4'd0);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 8'd200);
        check("t5_clamp", 32'(mon_dmg), 32'd255);

        // T6: reset mid-dodge
        k_step(4'd5); k_step(4'd0); k_step(4'd5); k_step(4'd0);
        step(1'b0, 4'd4, 1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 8'd0);
        check("t6_state", 32'(state), 32'h10);
        check("t6_instr", 32'(player_instr), 32'h0);

        // Random play
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] rk;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 4)       rk = 4'd0;
            else if (sel < 9)  rk = 4'($urandom_range(1, 5));
            else               rk = key;
            step(($urandom_range(0, 499) == 0),
                 rk,
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 60) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom_range(0, 40)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
